// File: rtl/simd_rf_pkg.sv
// Shared types and defaults for the SIMD vector register file.
package simd_rf_pkg;
  localparam int LANES_DEF  = 4;
  localparam int ELEM_W_DEF = 32;
  localparam int NREGS_DEF  = 32;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} rf_state_t;

  // Low bit of lane 'lane' in a flat vector of elem_w-bit elements.
  function automatic int lane_lo(input int lane, input int elem_w);
    return lane * elem_w;
  endfunction
endpackage

// File: rtl/simd_vec_reg_file_if.sv
// Operand-fetch / writeback bus of the vector register file.
interface simd_vec_reg_file_if import simd_rf_pkg::*; #(
  parameter int LANES  = LANES_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int NREGS  = NREGS_DEF
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [ADDR_W-1:0]       rd_addr1;
  logic [ADDR_W-1:0]       rd_addr2;
  logic [LANES*ELEM_W-1:0] rd_data1;
  logic [LANES*ELEM_W-1:0] rd_data2;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [LANES*ELEM_W-1:0] wr_data;
  logic [LANES-1:0]        wr_mask;
  logic                    clear_req;
  logic                    busy;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_mask, clear_req,
    input  rd_data1, rd_data2, busy
  );
  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, wr_mask, clear_req,
    output rd_data1, rd_data2, busy
  );
endinterface

// File: rtl/simd_rf_lane_bank.sv
// Storage for one lane of every vector register: one write port, two async read ports.
module simd_rf_lane_bank #(
  parameter int ELEM_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ELEM_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [ELEM_W-1:0] rdata1,
  output logic [ELEM_W-1:0] rdata2
);
  // No reset: contents are defined by the clear sweep, not by reset.
  logic [ELEM_W-1:0] mem [NREGS];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/simd_vec_reg_file.sv
// Vector register file: masked write, write-to-read bypass, optional zero r0,
// and a one-register-per-cycle clear sweep after reset or on clear_req.
module simd_vec_reg_file import simd_rf_pkg::*; #(
  parameter int LANES    = LANES_DEF,
  parameter int ELEM_W   = ELEM_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = $clog2(NREGS)
) (
  input logic               clk,
  input logic               reset,
  simd_vec_reg_file_if.slave rf
);
  rf_state_t                    state, state_nxt;
  logic [ADDR_W-1:0]            clr_cnt, clr_cnt_nxt;
  logic                         idle, wr_act, wr_zero, hit1, hit2;
  logic [ADDR_W-1:0]            bank_waddr;
  logic [LANES-1:0]             bank_we;
  logic [LANES-1:0][ELEM_W-1:0] wdata_v, bank_wdata, rdat1, rdat2, byp1, byp2;
  logic [LANES-1:0][ELEM_W-1:0] rd1_q, rd2_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(NREGS - 1)) state_nxt = IDLE;
      end
      IDLE: if (rf.clear_req) begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign idle       = (state == IDLE);
  assign rf.busy    = !idle;
  assign wr_act     = idle && rf.wr_en;
  assign wr_zero    = ZERO_REG && (rf.wr_addr == '0);
  assign hit1       = wr_act && (rf.wr_addr == rf.rd_addr1);
  assign hit2       = wr_act && (rf.wr_addr == rf.rd_addr2);
  assign bank_waddr = idle ? rf.wr_addr : clr_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LO = lane_lo(i, ELEM_W);
    assign wdata_v[i]    = rf.wr_data[LO +: ELEM_W];
    // The sweep owns every lane's write port while it runs.
    assign bank_we[i]    = !idle || (wr_act && rf.wr_mask[i] && !wr_zero);
    assign bank_wdata[i] = idle ? wdata_v[i] : '0;
    assign byp1[i]       = (hit1 && rf.wr_mask[i]) ? wdata_v[i] : rdat1[i];
    assign byp2[i]       = (hit2 && rf.wr_mask[i]) ? wdata_v[i] : rdat2[i];

    simd_rf_lane_bank #(.ELEM_W(ELEM_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_bank (
      .clk    (clk),
      .we     (bank_we[i]),
      .waddr  (bank_waddr),
      .wdata  (bank_wdata[i]),
      .raddr1 (rf.rd_addr1),
      .raddr2 (rf.rd_addr2),
      .rdata1 (rdat1[i]),
      .rdata2 (rdat2[i])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= (!idle || (ZERO_REG && rf.rd_addr1 == '0)) ? '0 : byp1;
      rd2_q <= (!idle || (ZERO_REG && rf.rd_addr2 == '0)) ? '0 : byp2;
    end

  assign rf.rd_data1 = rd1_q;
  assign rf.rd_data2 = rd2_q;
endmodule

// File: tb/tb_simd_vec_reg_file.sv
// Directed bench for simd_vec_reg_file with default parameters (4 x 32b lanes, 32 regs, zero r0).
module tb_simd_vec_reg_file;
  localparam int LANES = 4, ELEM_W = 32, NREGS = 32;
  localparam int DW = LANES * ELEM_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   chk = 0;
  int   pass = 0;

  simd_vec_reg_file_if #(.LANES(LANES), .ELEM_W(ELEM_W), .NREGS(NREGS)) rf ();

  simd_vec_reg_file #(.LANES(LANES), .ELEM_W(ELEM_W), .NREGS(NREGS), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cycle(input logic [4:0] a, input logic [DW-1:0] d, input logic [3:0] m);
    rf.wr_en = 1'b1; rf.wr_addr = a; rf.wr_data = d; rf.wr_mask = m;
    tick;
    rf.wr_en = 1'b0;
  endtask

  task automatic rd_cycle(input logic [4:0] a1, input logic [4:0] a2);
    rf.rd_addr1 = a1; rf.rd_addr2 = a2;
    tick;
  endtask

  function automatic logic [DW-1:0] pat(input int r);
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*ELEM_W +: ELEM_W] = 32'h0100_0000 * r + 32'h10 * l + 32'h5;
    return v;
  endfunction

  task automatic test_reset;
    int n, bad;
    tick; tick;
    chk++; if (rf.busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", rf.busy); else pass++;
    chk++; if (rf.rd_data1 !== '0) $display("FAIL reset_rd1: got %h expected 0", rf.rd_data1); else pass++;
    chk++; if (rf.rd_data2 !== '0) $display("FAIL reset_rd2: got %h expected 0", rf.rd_data2); else pass++;
    reset = 1'b0;
    n = 0; bad = 0;
    while (rf.busy === 1'b1 && n < 100) begin
      if (rf.rd_data1 !== '0 || rf.rd_data2 !== '0) bad++;
      rd_cycle(5'(n), 5'(31 - n));
      n++;
    end
    chk++; if (n !== 32) $display("FAIL reset_busy_len: got %0d cycles expected 32", n); else pass++;
    chk++; if (bad !== 0) $display("FAIL reset_rd_zero_while_busy: got %0d nonzero cycles expected 0", bad); else pass++;
    for (int r = 0; r < NREGS; r++) begin
      rd_cycle(5'(r), 5'(NREGS - 1 - r));
      chk++; if (rf.rd_data1 !== '0 || rf.rd_data2 !== '0)
        $display("FAIL reset_all_zero r%0d: got %h/%h expected 0", r, rf.rd_data1, rf.rd_data2); else pass++;
    end
  endtask

  task automatic test_masked_write;
    wr_cycle(5'd5, 128'h44444444_33333333_22222222_11111111, 4'b1111);
    wr_cycle(5'd5, {DW{1'b1}}, 4'b0101);
    wr_cycle(5'd6, {DW{1'b1}}, 4'b0000);
    rd_cycle(5'd5, 5'd6);
    chk++; if (rf.rd_data1 !== 128'h44444444_FFFFFFFF_22222222_FFFFFFFF)
      $display("FAIL masked_write: got %h expected 44444444ffffffff22222222ffffffff", rf.rd_data1); else pass++;
    chk++; if (rf.rd_data2 !== '0) $display("FAIL zero_mask_write: got %h expected 0", rf.rd_data2); else pass++;
  endtask

  task automatic test_bypass;
    rf.rd_addr1 = 5'd7; rf.rd_addr2 = 5'd7;
    wr_cycle(5'd7, {4{32'hAAAAAAAA}}, 4'b0011);
    chk++; if (rf.rd_data1 !== 128'h0_AAAAAAAA_AAAAAAAA)
      $display("FAIL bypass_rd1: got %h expected 0000000000000000aaaaaaaaaaaaaaaa", rf.rd_data1); else pass++;
    chk++; if (rf.rd_data2 !== 128'h0_AAAAAAAA_AAAAAAAA)
      $display("FAIL bypass_rd2: got %h expected 0000000000000000aaaaaaaaaaaaaaaa", rf.rd_data2); else pass++;
    // independent ports: port 2 reads r5 while r7 is written
    rf.rd_addr1 = 5'd7; rf.rd_addr2 = 5'd5;
    wr_cycle(5'd7, {4{32'h12345678}}, 4'b1000);
    chk++; if (rf.rd_data1 !== 128'h12345678_00000000_AAAAAAAA_AAAAAAAA)
      $display("FAIL bypass_partial: got %h expected 1234567800000000aaaaaaaaaaaaaaaa", rf.rd_data1); else pass++;
    chk++; if (rf.rd_data2 !== 128'h44444444_FFFFFFFF_22222222_FFFFFFFF)
      $display("FAIL bypass_other_port: got %h expected 44444444ffffffff22222222ffffffff", rf.rd_data2); else pass++;
    rd_cycle(5'd7, 5'd7);
    chk++; if (rf.rd_data2 !== 128'h12345678_00000000_AAAAAAAA_AAAAAAAA)
      $display("FAIL bypass_stored: got %h expected 1234567800000000aaaaaaaaaaaaaaaa", rf.rd_data2); else pass++;
  endtask

  task automatic test_zero_reg;
    rf.rd_addr1 = 5'd0; rf.rd_addr2 = 5'd0;
    wr_cycle(5'd0, {4{32'hDEADBEEF}}, 4'b1111);
    chk++; if (rf.rd_data1 !== '0 || rf.rd_data2 !== '0)
      $display("FAIL zero_reg_same_cycle: got %h/%h expected 0", rf.rd_data1, rf.rd_data2); else pass++;
    rd_cycle(5'd0, 5'd0);
    chk++; if (rf.rd_data1 !== '0 || rf.rd_data2 !== '0)
      $display("FAIL zero_reg_next: got %h/%h expected 0", rf.rd_data1, rf.rd_data2); else pass++;
  endtask

  task automatic test_clear_req;
    int n, bad;
    for (int r = 1; r < NREGS; r++) wr_cycle(5'(r), pat(r), 4'b1111);
    rd_cycle(5'd3, 5'd31);
    chk++; if (rf.rd_data1 !== pat(3) || rf.rd_data2 !== pat(31))
      $display("FAIL populate: got %h/%h expected %h/%h", rf.rd_data1, rf.rd_data2, pat(3), pat(31)); else pass++;
    rf.clear_req = 1'b1;
    tick;
    rf.clear_req = 1'b0;
    chk++; if (rf.busy !== 1'b1) $display("FAIL clear_busy_start: got %b expected 1", rf.busy); else pass++;
    n = 0; bad = 0;
    while (rf.busy === 1'b1 && n < 100) begin
      if (n == 10) begin rf.wr_en = 1'b1; rf.wr_addr = 5'd3; rf.wr_data = {4{32'hCAFEF00D}}; rf.wr_mask = 4'hF; end
      if (n == 15) rf.clear_req = 1'b1;
      rf.rd_addr1 = 5'd3; rf.rd_addr2 = 5'd31;
      tick;
      rf.wr_en = 1'b0; rf.clear_req = 1'b0;
      if (rf.rd_data1 !== '0 || rf.rd_data2 !== '0) bad++;
      n++;
    end
    chk++; if (n !== 32) $display("FAIL clear_busy_len: got %0d cycles expected 32", n); else pass++;
    chk++; if (bad !== 0) $display("FAIL clear_rd_zero_while_busy: got %0d nonzero cycles expected 0", bad); else pass++;
    for (int r = 0; r < NREGS; r++) begin
      rd_cycle(5'(r), 5'(NREGS - 1 - r));
      chk++; if (rf.rd_data1 !== '0 || rf.rd_data2 !== '0)
        $display("FAIL clear_all_zero r%0d: got %h/%h expected 0", r, rf.rd_data1, rf.rd_data2); else pass++;
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    wr_cycle(5'd3, pat(3), 4'b1111);
    rf.clear_req = 1'b1;
    tick;
    rf.clear_req = 1'b0;
    for (int c = 0; c < 15; c++) tick;
    reset = 1'b1;
    tick;
    chk++; if (rf.busy !== 1'b1) $display("FAIL midreset_busy: got %b expected 1", rf.busy); else pass++;
    reset = 1'b0;
    n = 0;
    while (rf.busy === 1'b1 && n < 100) begin tick; n++; end
    chk++; if (n !== 32) $display("FAIL midreset_busy_len: got %0d cycles expected 32", n); else pass++;
    // first idle cycle: write accepted and bypassed on port 2
    rf.rd_addr1 = 5'd3; rf.rd_addr2 = 5'd9;
    wr_cycle(5'd9, pat(9), 4'b1111);
    chk++; if (rf.rd_data1 !== '0) $display("FAIL midreset_r3_zero: got %h expected 0", rf.rd_data1); else pass++;
    chk++; if (rf.rd_data2 !== pat(9)) $display("FAIL first_idle_bypass: got %h expected %h", rf.rd_data2, pat(9)); else pass++;
    rd_cycle(5'd9, 5'd31);
    chk++; if (rf.rd_data1 !== pat(9)) $display("FAIL first_idle_write: got %h expected %h", rf.rd_data1, pat(9)); else pass++;
    chk++; if (rf.rd_data2 !== '0) $display("FAIL midreset_r31_zero: got %h expected 0", rf.rd_data2); else pass++;
  endtask

  initial begin
    rf.rd_addr1 = '0; rf.rd_addr2 = '0; rf.wr_en = 1'b0; rf.wr_addr = '0;
    rf.wr_data = '0; rf.wr_mask = '0; rf.clear_req = 1'b0;
    test_reset;
    test_masked_write;
    test_bypass;
    test_zero_reg;
    test_clear_req;
    test_reset_mid_sweep;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/simd_vec_reg_file.md
# simd_vec_reg_file

Parametrised vector register file for the SIMD RISC core: NREGS registers, each holding LANES elements of ELEM_W bits. It has two registered read ports, one write port with a per-lane write mask, write-to-read bypass, an optional hardwired-zero register 0, and a sequential clear engine that zeroes the array after reset or on request. It sits between decode (operand fetch) and the SIMD ALU writeback stage.

## Interface
- LANES, 4, number of SIMD lanes per register
- ELEM_W, 32, bits per lane element
- NREGS, 32, number of vector registers (power of two, ≥2)
- ZERO_REG, 1, when 1 register 0 always reads zero and ignores writes
- ADDR_W, $clog2(NREGS), derived register address width
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  LANES*ELEM_W  read port 1 data, lane i at [i*ELEM_W +: ELEM_W]
- rd_data2  out  LANES*ELEM_W  read port 2 data, same packing
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  LANES*ELEM_W  write data, same packing
- wr_mask  in  LANES  per-lane write enable; lane i is written only if wr_mask[i]=1
- clear_req  in  1  single-cycle pulse that starts a full-array clear
- busy  out  1  high while the clear engine runs

## Operation
- FSM states: CLEAR, IDLE. Reset forces CLEAR with clr_cnt=0.
- CLEAR: each cycle writes zero to all lanes of register clr_cnt, then increments clr_cnt. When clr_cnt=NREGS-1 is written, the FSM goes to IDLE.
- In IDLE, clear_req=1 sets clr_cnt=0 and moves the FSM to CLEAR.
- clear_req is ignored while in CLEAR. The sweep is not restarted.
- While busy, wr_en is ignored (the write is dropped, not queued) and both rd_data outputs register zero.
- In IDLE, a write with wr_en=1 updates only the lanes of wr_addr whose mask bit is set. Other lanes keep their value.
- If wr_en=1 and wr_mask=0, nothing changes.
- If ZERO_REG=1, writes to address 0 are discarded and reads of address 0 return zero regardless of bypass.
- Bypass: if wr_en=1 (IDLE) and wr_addr equals rd_addrN in the same cycle, rd_dataN returns wr_data for masked lanes and the stored value for unmasked lanes. Both ports bypass independently.
- Both ports may read the same address at once.

## Timing
- Read latency is 1 cycle. The address sampled at edge N gives data on rd_dataN after edge N, and it is held until the next edge.
- Write latency is 1 cycle. Data written at edge N is visible to a read sampled at edge N+1, and through bypass to a read sampled at edge N itself.
- Reset values: rd_data1=0, rd_data2=0, busy=1, state=CLEAR, clr_cnt=0.
- Clear duration is exactly NREGS cycles after reset deassertion, or after the clear_req edge. busy falls at the edge that writes register NREGS-1.
- A write in the first cycle with busy=0 is accepted.
- Reset asserted mid-clear or mid-operation immediately restarts CLEAR from clr_cnt=0. Partially cleared contents are not trusted.
- Array contents are undefined only until the sweep completes. After that they are fully defined.

## Structure
- Shared package simd_rf_pkg holds:
  - default LANES/ELEM_W/NREGS constants
  - the rf_state_t enum {CLEAR, IDLE}
  - a lane-slice helper function
- Sub-module simd_rf_lane_bank: one per lane (generated LANES times). Each holds NREGS×ELEM_W storage with one write port (lane write enable = wr_mask[i] or clear) and two read ports.
- Bypass muxing, the zero-register logic and the FSM live in the top level.

## Test plan
- Reset, then release → busy=1 for exactly 32 cycles, rd_data1/2=0 throughout. Afterwards, reading every register returns 0.
- Write r5 = {0x44444444, 0x33333333, 0x22222222, 0x11111111} with mask 4'b1111. Then write r5 = all 0xFFFFFFFF with mask 4'b0101 → read r5 = {0x44444444, 0xFFFFFFFF, 0x22222222, 0xFFFFFFFF}.
- Same cycle: write r7 = 0xAAAAAAAA in all lanes with mask 4'b0011, and rd_addr1=rd_addr2=7 with r7 previously 0 → both ports show {0, 0, 0xAAAAAAAA, 0xAAAAAAAA} one cycle later.
- ZERO_REG=1: write r0 = 0xDEADBEEF in all lanes with mask 4'b1111, reading r0 in the same cycle and the next → both reads return 0.
- Populate r1..r31, pulse clear_req, and attempt a write to r3 on cycle 10 of the sweep → busy=1 for 32 cycles, the write is dropped, and all registers read 0 afterwards. A second clear_req mid-sweep does not extend busy.
- Assert reset at cycle 15 of a sweep for 1 cycle → busy remains high for 32 cycles from the reset release, and all registers read 0.
